rxcver_fifo_param: RTL

Parametrised receive FIFO for the UART receiver path, replacing the fixed 16x(8+3) RX FIFO.
- Stores each received character together with its per-character error sideband (parity, framing, break) in a single entry.
- Adds a fill count, programmable almost-full/almost-empty thresholds, a sticky overrun flag and an "error in FIFO" summary for the line-status register.
- Sits between the rxcver bit engine (write side) and the register interface (read side); single clock domain.

---
 rtl/rxfifo_pkg.sv | 22 ++
 rtl/rxfifo_timeout_ctr.sv | 30 +++
 rtl/rxcver_fifo_param.sv | 104 ++++++++++
 3 files changed

// File: rtl/rxfifo_pkg.sv
// Shared constants and helpers for the UART receive FIFO.
package rxfifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ERR_WIDTH  = 3;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_TO_TICKS   = 40;

  // Entry layout: {char, err}, error sideband in the low bits
  localparam int unsigned ERR_LSB  = 0;
  localparam int unsigned CHAR_LSB = ERR_LSB + DEF_ERR_WIDTH;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rxfifo_timeout_ctr.sv
// Character-timeout counter: counts bit-time ticks while data waits unread.
module rxfifo_timeout_ctr
  import rxfifo_pkg::*;
#(
  parameter int unsigned TO_TICKS = DEF_TO_TICKS
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Tick,
  input  logic Clear,
  output logic Timeout
);

  localparam int unsigned CW = clog2(TO_TICKS + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (Clear) begin
      cnt <= '0;
    end else if (Tick && (cnt != CW'(TO_TICKS))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign Timeout = (cnt == CW'(TO_TICKS));

endmodule

// File: rtl/rxcver_fifo_param.sv
// Parametrised UART receive FIFO with error sideband, fill count and status flags.
// Optional character timeout built when RXCVER_FIFO_TIMEOUT_EN is defined.
module rxcver_fifo_param
  import rxfifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ERR_WIDTH  = DEF_ERR_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned TO_TICKS   = DEF_TO_TICKS,
  localparam int unsigned AW        = clog2(DEPTH)
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic [DATA_WIDTH+ERR_WIDTH-1:0] Data,
  input  logic                            WrEn,
  input  logic                            RdEn,
  input  logic                            Flush,
  input  logic                            ClrOverrun,
  input  logic [AW:0]                     AfullThresh,
  input  logic [AW:0]                     AemptyThresh,
  input  logic                            TimeoutTick,
  output logic [DATA_WIDTH-1:0]           Q,
  output logic [ERR_WIDTH-1:0]            Q_error,
  output logic [AW:0]                     Count,
  output logic                            Empty,
  output logic                            Full,
  output logic                            AlmostEmpty,
  output logic                            AlmostFull,
  output logic                            Overrun,
  output logic                            ErrInFifo,
  output logic                            Timeout
);

  localparam int unsigned EW       = DATA_WIDTH + ERR_WIDTH;
  localparam int unsigned CHAR_POS = ERR_LSB + ERR_WIDTH;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wp, rp, err_cnt;
  logic [EW-1:0] head;
  logic          wr_ok, rd_ok, err_in, err_out, ovr_set;

  assign Count       = wp - rp;
  assign Empty       = (Count == '0);
  assign Full        = (Count == (AW+1)'(DEPTH));
  assign AlmostFull  = (Count >= AfullThresh);
  assign AlmostEmpty = (Count <= AemptyThresh);
  assign ErrInFifo   = (err_cnt != '0);

  // A full FIFO still accepts a write when the same cycle pops the head slot
  assign wr_ok   = WrEn && (!Full || RdEn);
  assign rd_ok   = RdEn && !Empty;
  assign ovr_set = WrEn && Full && !RdEn && !Flush;

  assign head    = mem[rp[AW-1:0]];
  assign Q       = Empty ? '0 : head[CHAR_POS +: DATA_WIDTH];
  assign Q_error = Empty ? '0 : head[ERR_LSB +: ERR_WIDTH];
  assign err_in  = |Data[ERR_LSB +: ERR_WIDTH];
  assign err_out = |Q_error;

  always_ff @(posedge Clock) begin
    if (wr_ok && !Flush) mem[wp[AW-1:0]] <= Data;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wp      <= '0;
      rp      <= '0;
      err_cnt <= '0;
      Overrun <= 1'b0;
    end else begin
      if (Flush) begin
        wp      <= '0;
        rp      <= '0;
        err_cnt <= '0;
      end else begin
        wp <= wp + (AW+1)'(wr_ok);
        rp <= rp + (AW+1)'(rd_ok);
        if ((wr_ok && err_in) && !(rd_ok && err_out))
          err_cnt <= err_cnt + 1'b1;
        else if ((rd_ok && err_out) && !(wr_ok && err_in))
          err_cnt <= err_cnt - 1'b1;
      end
      if (ovr_set)
        Overrun <= 1'b1;
      else if (ClrOverrun || Flush)
        Overrun <= 1'b0;
    end
  end

`ifdef RXCVER_FIFO_TIMEOUT_EN
  rxfifo_timeout_ctr #(.TO_TICKS(TO_TICKS)) u_timeout (
    .Clock   (Clock),
    .Reset   (Reset),
    .Tick    (TimeoutTick),
    .Clear   (wr_ok || rd_ok || Flush || Empty),
    .Timeout (Timeout)
  );
`else
  logic unused_tick;
  assign unused_tick = TimeoutTick;
  assign Timeout     = 1'b0;
`endif

endmodule
